// File: rtl/rng_mask_collect_if.sv
// Bundle of handshake signals between the mask collector, its byte RNG and
// the mask consumer.
//   en          : continuous mask generation request (environment -> collector)
//   rng_rd      : RNG read strobe, byte consumed in the cycle it is high
//   rng_byte    : RNG data byte, valid whenever rng_rd is high
//   mask        : head entry of the collector output buffer
//   mask_valid  : output buffer not empty
//   mask_ready  : consumer accept; pop when mask_valid && mask_ready
//   mask_cnt    : saturating count of masks written to the buffer
// The master modport is the collector side; the slave modport is the
// environment (RNG plus consumer) side.
interface rng_mask_collect_if #(
    parameter int MASK_BYTES = 8
);
    logic                    en;
    logic                    rng_rd;
    logic [7:0]              rng_byte;
    logic [8*MASK_BYTES-1:0] mask;
    logic                    mask_valid;
    logic                    mask_ready;
    logic [15:0]             mask_cnt;

    modport master (
        input  en, rng_byte, mask_ready,
        output rng_rd, mask, mask_valid, mask_cnt
    );

    modport slave (
        output en, rng_byte, mask_ready,
        input  rng_rd, mask, mask_valid, mask_cnt
    );
endinterface

// File: rtl/rng_mask_collect.sv
// Collects bytes from a byte-wide RNG into masks of 8*MASK_BYTES bits and
// hands them to a consumer through a 2-entry output FIFO.
//   clk   : single clock, rising edge
//   vrst  : asynchronous active-low reset (clears everything)
//   rst   : synchronous active-high soft clear (keeps mask_cnt)
//   bus   : master side of rng_mask_collect_if (en, RNG strobe/data,
//           mask/valid/ready handshake, mask_cnt)
// Bytes shift in from the top, so the first byte read ends up in mask[7:0].
// A word in progress always completes even if en drops; only rst/vrst can
// discard a partial word.
module rng_mask_collect #(
    parameter int MASK_BYTES = 8
) (
    input  logic                clk,
    input  logic                vrst,
    input  logic                rst,
    rng_mask_collect_if.master  bus
);
    localparam int W  = 8 * MASK_BYTES;
    localparam int BW = $clog2(MASK_BYTES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    localparam logic [BW-1:0] BCNT_LAST = BW'(MASK_BYTES - 1);
    localparam logic [BW-1:0] BCNT_ONE  = BW'(1);

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [BW-1:0] bcnt_r;
    logic [BW-1:0] bcnt_nxt_s;
    logic [W-1:0]  asm_r;
    logic [W-1:0]  asm_nxt_s;
    logic [W-1:0]  word_s;
    logic [W-1:0]  buf0_r;
    logic [W-1:0]  buf1_r;
    logic [W-1:0]  buf0_nxt_s;
    logic [W-1:0]  buf1_nxt_s;
    logic [1:0]    occ_r;
    logic [1:0]    occ_nxt_s;
    logic [15:0]   cnt_r;
    logic [15:0]   cnt_nxt_s;
    logic          rd_r;
    logic          valid_r;
    logic          fill_s;
    logic          wr_s;
    logic          pop_s;

    // Word assembly and handshake qualifiers.
    always_comb begin
        word_s = {bus.rng_byte, asm_r[W-1:8]};
        fill_s = (state_r == ST_FILL);
        wr_s   = fill_s && (bcnt_r == BCNT_LAST);
        pop_s  = (occ_r != 2'd0) && bus.mask_ready;
    end

    // Next assembly register and byte counter.
    always_comb begin
        asm_nxt_s  = asm_r;
        bcnt_nxt_s = bcnt_r;
        if (wr_s) begin
            asm_nxt_s  = word_s;
            bcnt_nxt_s = '0;
        end else if (fill_s) begin
            asm_nxt_s  = word_s;
            bcnt_nxt_s = bcnt_r + BCNT_ONE;
        end else begin
            asm_nxt_s  = asm_r;
            bcnt_nxt_s = bcnt_r;
        end
    end

    // Output FIFO: buf0_r is always the head, so mask comes straight from a flop.
    always_comb begin
        occ_nxt_s  = occ_r;
        buf0_nxt_s = buf0_r;
        buf1_nxt_s = buf1_r;
        case ({wr_s, pop_s})
            2'b10: begin
                occ_nxt_s = occ_r + 2'd1;
                if (occ_r == 2'd0) begin
                    buf0_nxt_s = word_s;
                end else begin
                    buf1_nxt_s = word_s;
                end
            end
            2'b01: begin
                occ_nxt_s = occ_r - 2'd1;
                if (occ_r == 2'd2) begin
                    buf0_nxt_s = buf1_r;
                end else begin
                    buf0_nxt_s = buf0_r;
                end
            end
            2'b11: begin
                occ_nxt_s = occ_r;
                if (occ_r == 2'd2) begin
                    buf0_nxt_s = buf1_r;
                    buf1_nxt_s = word_s;
                end else begin
                    buf0_nxt_s = word_s;
                end
            end
            default: begin
                occ_nxt_s = occ_r;
            end
        endcase
    end

    // Saturating count of buffer writes.
    always_comb begin
        if (wr_s && (cnt_r != 16'hFFFF)) begin
            cnt_nxt_s = cnt_r + 16'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // FSM next state; decisions use the occupancy after this edge's write/pop.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.en) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (wr_s) begin
                    if (occ_nxt_s == 2'd2) begin
                        state_nxt_s = ST_STALL;
                    end else if (bus.en) begin
                        state_nxt_s = ST_FILL;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_STALL: begin
                if (occ_nxt_s == 2'd2) begin
                    state_nxt_s = ST_STALL;
                end else if (bus.en) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State registers; the soft clear keeps the mask counter.
    always_ff @(posedge clk or negedge vrst) begin
        if (!vrst) begin
            state_r <= ST_IDLE;
            bcnt_r  <= '0;
            asm_r   <= '0;
            buf0_r  <= '0;
            buf1_r  <= '0;
            occ_r   <= 2'd0;
            cnt_r   <= 16'd0;
            rd_r    <= 1'b0;
            valid_r <= 1'b0;
        end else if (rst) begin
            state_r <= ST_IDLE;
            bcnt_r  <= '0;
            asm_r   <= '0;
            buf0_r  <= '0;
            buf1_r  <= '0;
            occ_r   <= 2'd0;
            rd_r    <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            bcnt_r  <= bcnt_nxt_s;
            asm_r   <= asm_nxt_s;
            buf0_r  <= buf0_nxt_s;
            buf1_r  <= buf1_nxt_s;
            occ_r   <= occ_nxt_s;
            cnt_r   <= cnt_nxt_s;
            rd_r    <= (state_nxt_s == ST_FILL);
            valid_r <= (occ_nxt_s != 2'd0);
        end
    end

    assign bus.rng_rd     = rd_r;
    assign bus.mask       = buf0_r;
    assign bus.mask_valid = valid_r;
    assign bus.mask_cnt   = cnt_r;
endmodule

// File: tb/tb_rng_mask_collect.sv
// Self-checking bench for rng_mask_collect: a directed table, hand-written
// corner sequences and a random phase, all compared every cycle against a
// behavioural model built from byte and mask queues.
module tb_rng_mask_collect;
    localparam int MB = 8;
    localparam int W  = 8 * MB;

    logic clk = 1'b0;
    logic vrst;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rng_mask_collect_if #(.MASK_BYTES(MB)) bus ();

    rng_mask_collect #(.MASK_BYTES(MB)) dut (
        .clk  (clk),
        .vrst (vrst),
        .rst  (rst),
        .bus  (bus)
    );

    // Reference model: reads whenever a word is partly collected, or when
    // en is high and the buffer has room for another word.
    bit           m_active;
    logic [7:0]   m_bytes[$];
    logic [W-1:0] m_q[$];
    int           m_cnt;

    typedef struct {
        bit          en;
        bit          ready;
        logic [7:0]  b;
        bit          e_rd;
        bit          e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset(input bit hard);
        m_active = 1'b0;
        m_bytes.delete();
        m_q.delete();
        if (hard) m_cnt = 0;
    endtask

    task automatic model_step(input bit en, input bit ready, input bit rs, input logic [7:0] b);
        logic [W-1:0] w;
        bit done;
        w = '0;
        done = 1'b0;
        if (rs) begin
            model_reset(1'b0);
        end else begin
            if (m_active) begin
                m_bytes.push_back(b);
                if (m_bytes.size() == MB) begin
                    for (int i = 0; i < MB; i++) w = w | (W'(m_bytes[i]) << (8 * i));
                    m_bytes.delete();
                    done = 1'b1;
                end
            end
            if (ready && m_q.size() != 0) m_q.delete(0);
            if (done) begin
                m_q.push_back(w);
                if (m_cnt < 65535) m_cnt++;
            end
            m_active = (m_bytes.size() != 0) || (en && m_q.size() < 2);
        end
    endtask

    task automatic check_outputs();
        chk1("rng_rd", bus.rng_rd, m_active);
        chk1("mask_valid", bus.mask_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("mask", 64'(bus.mask), 64'(m_q[0]));
        chk("mask_cnt", 64'(bus.mask_cnt), 64'(m_cnt));
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic cycle_b(input bit en, input bit ready, input bit rs, input logic [7:0] b);
        bus.en = en;
        bus.mask_ready = ready;
        rst = rs;
        bus.rng_byte = b;
        @(posedge clk);
        model_step(en, ready, rs, b);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cycle(input bit en, input bit ready, input bit rs);
        logic [7:0] b;
        b = 8'($urandom);
        cycle_b(en, ready, rs, b);
    endtask

    // A buffer write must never find both entries occupied.
    always @(posedge clk) begin
        if (vrst && !rst && dut.wr_s) begin
            checks++;
            if (dut.occ_r == 2'd2) begin
                errors++;
                $display("FAIL write_when_full: occ %0d expected below 2", dut.occ_r);
            end
        end
    end

    initial begin
        int cnt0;
        int rd_n;

        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 1'b0, 8'(i * 17), (i < 8), (i == 8), ((i == 8) ? 16'd1 : 16'd0)};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd1};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'd1};

        vrst = 1'b0;
        rst = 1'b0;
        bus.en = 1'b0;
        bus.mask_ready = 1'b0;
        bus.rng_byte = 8'h00;
        model_reset(1'b1);
        repeat (3) @(negedge clk);
        chk1("reset_rd", bus.rng_rd, 1'b0);
        chk1("reset_valid", bus.mask_valid, 1'b0);
        chk("reset_mask", 64'(bus.mask), 64'h0);
        chk("reset_cnt", 64'(bus.mask_cnt), 64'h0);
        vrst = 1'b1;

        // Single mask from a one-cycle en pulse.
        for (int i = 0; i < 11; i++) begin
            cycle_b(tbl[i].en, tbl[i].ready, 1'b0, tbl[i].b);
            chk1("tbl_rd", bus.rng_rd, tbl[i].e_rd);
            chk1("tbl_valid", bus.mask_valid, tbl[i].e_valid);
            chk("tbl_cnt", 64'(bus.mask_cnt), 64'(tbl[i].e_cnt));
            if (i == 9) chk("tbl_mask", 64'(bus.mask), 64'h8877665544332211);
        end

        // Backpressure: two masks buffered, reading stops; one pop restarts it.
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        chk1("bp_stall_rd", bus.rng_rd, 1'b0);
        chk("bp_occ", 64'(dut.occ_r), 64'd2);
        cycle(1'b1, 1'b1, 1'b0);
        chk1("bp_resume_rd", bus.rng_rd, 1'b1);
        chk1("bp_valid", bus.mask_valid, 1'b1);
        repeat (20) cycle(1'b0, 1'b1, 1'b0);
        chk1("bp_drained", bus.mask_valid, 1'b0);

        // Streaming: 80 read cycles give 10 masks without bubbles.
        cnt0 = m_cnt;
        for (int i = 0; i < 81; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            chk1("stream_rd", bus.rng_rd, 1'b1);
            chk1("stream_occ_le1", dut.occ_r <= 2'd1, 1'b1);
        end
        chk("stream_cnt", 64'(bus.mask_cnt), 64'(cnt0 + 10));
        repeat (12) cycle(1'b0, 1'b1, 1'b0);

        // en dropped after 3 bytes: the word still completes.
        cnt0 = m_cnt;
        rd_n = 0;
        cycle(1'b1, 1'b0, 1'b0);
        rd_n += int'(bus.rng_rd);
        repeat (3) begin
            cycle(1'b1, 1'b0, 1'b0);
            rd_n += int'(bus.rng_rd);
        end
        repeat (8) begin
            cycle(1'b0, 1'b0, 1'b0);
            rd_n += int'(bus.rng_rd);
        end
        chk("midword_rd_cycles", 64'(rd_n), 64'd8);
        chk("midword_cnt", 64'(bus.mask_cnt), 64'(cnt0 + 1));
        chk1("midword_valid", bus.mask_valid, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);

        // Soft clear after 5 bytes of a second word with one mask buffered.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (13) cycle(1'b1, 1'b0, 1'b0);
        cnt0 = m_cnt;
        cycle(1'b1, 1'b1, 1'b1);
        chk1("srst_valid", bus.mask_valid, 1'b0);
        chk1("srst_rd", bus.rng_rd, 1'b0);
        chk("srst_bcnt", 64'(dut.bcnt_r), 64'd0);
        chk("srst_cnt", 64'(bus.mask_cnt), 64'(cnt0));
        rd_n = 0;
        cycle(1'b1, 1'b0, 1'b0);
        rd_n += int'(bus.rng_rd);
        repeat (8) begin
            cycle(1'b0, 1'b0, 1'b0);
            rd_n += int'(bus.rng_rd);
        end
        chk("srst_new_rd_cycles", 64'(rd_n), 64'd8);
        chk1("srst_new_valid", bus.mask_valid, 1'b1);

        // Asynchronous reset between edges while filling.
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        #2;
        vrst = 1'b0;
        #1;
        model_reset(1'b1);
        chk1("areset_rd", bus.rng_rd, 1'b0);
        chk1("areset_valid", bus.mask_valid, 1'b0);
        chk("areset_mask", 64'(bus.mask), 64'h0);
        chk("areset_cnt", 64'(bus.mask_cnt), 64'h0);
        chk("areset_bcnt", 64'(dut.bcnt_r), 64'h0);
        chk("areset_occ", 64'(dut.occ_r), 64'h0);
        @(posedge clk);
        @(negedge clk);
        vrst = 1'b1;
        check_outputs();

        // Random traffic with occasional soft clears.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rng_mask_collect.md
RNG_MASK_COLLECT -- requirements
Module: rng_mask_collect

Interface
REQ-001 Parameter MASK_BYTES, default 8, SHALL set the mask width to 8*MASK_BYTES bits; legal values are 2..16.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 vrst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 rst  input  1  SHALL be a synchronous soft clear, active-high.
REQ-005 en  input  1  SHALL request continuous mask generation.
REQ-006 rng_rd  output  1  SHALL be the read strobe to the byte RNG; high means the byte is consumed this cycle.
REQ-007 rng_byte  input  8  SHALL be the RNG byte, valid in every cycle in which rng_rd is high.
REQ-008 mask  output  8*MASK_BYTES  SHALL be the head mask word of the output buffer.
REQ-009 mask_valid  output  1  SHALL be high when the output buffer is not empty.
REQ-010 mask_ready  input  1  SHALL be the consumer accept signal; a pop occurs when mask_valid and mask_ready are both high.
REQ-011 mask_cnt  output  16  SHALL count masks written to the buffer and saturate at 16'hFFFF.

Function
REQ-012 The FSM SHALL have three states: IDLE, FILL and STALL; rng_rd SHALL be 1 only in FILL (Moore output).
REQ-013 IDLE -> FILL on en=1; otherwise remain in IDLE.
REQ-014 FILL: each cycle, rng_byte SHALL shift into the assembly register from the top (asm <= {rng_byte, asm[hi:8]}), and byte counter bcnt SHALL increment.
REQ-015 Result of REQ-014: the first byte read lands in mask[7:0] and the last in the top byte.
REQ-016 When bcnt==MASK_BYTES-1 in FILL, the completed word SHALL be written to the buffer and bcnt SHALL return to 0.
REQ-017 On that same edge, the next state SHALL be STALL if buffer occupancy after the write is 2, else IDLE if en=0, else FILL.
REQ-018 en deasserted mid-word SHALL NOT abort the word; FILL continues until the word completes, and partial words are never dropped or emitted.
REQ-019 STALL -> FILL when occupancy<2 and en=1; STALL -> IDLE when occupancy<2 and en=0; otherwise remain in STALL.
REQ-020 The output buffer SHALL be a 2-entry FIFO with occupancy occ in 0..2; mask SHALL show the oldest entry, and mask_valid = (occ!=0).
REQ-021 A write and a pop in the same cycle SHALL leave occ unchanged and preserve order.
REQ-022 A write with occ==2 SHALL be unreachable; the bench asserts it never occurs.
REQ-023 A pop with occ==0 SHALL have no effect.
REQ-024 mask SHALL remain stable while mask_valid=1 and mask_ready=0.
REQ-025 Latency: en rising in IDLE at edge N gives rng_rd high for cycles N+1..N+MASK_BYTES and mask_valid=1 after edge N+MASK_BYTES.
REQ-026 With mask_ready held at 1 and en at 1, rng_rd SHALL stay high continuously, giving one mask per MASK_BYTES cycles with no bubbles.
REQ-027 mask_cnt SHALL increment by 1 on each buffer write, saturating at 16'hFFFF.

Reset
REQ-028 vrst=0 SHALL immediately (asynchronously) force the following: state=IDLE, bcnt=0, asm=0, occ=0, both buffer entries=0, mask_cnt=0.
REQ-029 Consequently, during vrst=0: rng_rd=0, mask_valid=0, mask=0.
REQ-030 rst=1 at an edge with vrst=1 SHALL clear state, bcnt, asm, occ and buffer entries as in REQ-028, and SHALL retain mask_cnt.
REQ-031 rst SHALL take priority over en, mask_ready and any in-progress word; a partial word is discarded.
REQ-032 vrst deassertion SHALL be synchronised externally; the block SHALL be in IDLE on the first active edge after release.

Verification
REQ-033 Reset and single mask: release vrst, pulse en for 1 cycle, rng_byte=8'h11,22,...,88 on successive rd cycles -> exactly 8 rd cycles, mask=64'h8877665544332211, mask_valid=1, mask_cnt=1, then IDLE.
REQ-034 Backpressure: en=1, mask_ready=0 -> two masks buffered, state STALL, rng_rd=0; mask_ready=1 for 1 cycle -> first mask popped, FILL resumes the next cycle, order preserved.
REQ-035 Streaming: en=1, mask_ready=1 for 80 cycles -> rng_rd continuously high, 10 masks, each equal to the byte stream grouped LSB-first, occ never exceeds 1.
REQ-036 Mid-word en drop: deassert en after the 3rd byte -> the remaining 5 bytes are still read, 1 complete mask is emitted, then IDLE.
REQ-037 rst after the 5th byte of a word, with one mask buffered -> the next cycle shows mask_valid=0, rng_rd=0, bcnt=0, mask_cnt unchanged; a new request yields a fresh 8-byte word.
REQ-038 Async reset mid-FILL: drop vrst between clock edges -> rng_rd and mask_valid go to 0 before the next edge, and all counters are 0.
